// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: key input and entry/commit result bundle for keypad_entry_ctrl.
`default_nettype none

interface keypad_entry_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [3:0]          key_data;
    logic                key_flag;
    logic [4*DIGITS-1:0] entry;
    logic [3:0]          entry_cnt;
    logic [4*DIGITS-1:0] value;
    logic                value_valid;
    logic                err;
    logic                timeout;

    modport master (
        output key_data, key_flag,
        input  entry, entry_cnt, value, value_valid, err, timeout
    );

    modport slave (
        input  key_data, key_flag,
        output entry, entry_cnt, value, value_valid, err, timeout
    );
endinterface

`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: multi-digit BCD entry with backspace/clear/enter and a one-cycle commit pulse.
// Optional inactivity timeout enabled by defining ENTRY_TIMEOUT_EN.
`default_nettype none

module keypad_entry_ctrl #(
    parameter int DIGITS     = 4,
    parameter int T1ms       = 50_000,
    parameter int TIMEOUT_MS = 5000
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    keypad_entry_ctrl_if.slave  bus
);
    localparam int c_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTRY  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [c_W-1:0] r_entry, w_entry_nxt;
    logic [c_W-1:0] r_value, w_value_nxt;
    logic [3:0]     r_cnt, w_cnt_nxt;
    logic           r_valid, w_valid_nxt;
    logic           r_err, w_err_nxt;
    logic [c_W+3:0] w_shl_wide;
    logic           w_expire;

    // Widened concatenation keeps the shift-in legal even when DIGITS == 1.
    assign w_shl_wide = {r_entry, bus.key_data};

`ifdef ENTRY_TIMEOUT_EN
    localparam int c_PW = (T1ms > 1) ? $clog2(T1ms) : 1;
    localparam int c_IW = $clog2(TIMEOUT_MS + 1);

    logic [c_PW-1:0] r_ms_cnt;
    logic [c_IW-1:0] r_idle_ms;
    logic            r_timeout;
    logic            w_ms_tick;

    assign w_ms_tick = (r_ms_cnt == c_PW'(T1ms - 1));
    // A key arriving in the expiry cycle wins over the timeout.
    assign w_expire  = (r_state == S_ENTRY) && !bus.key_flag
                       && (r_idle_ms == c_IW'(TIMEOUT_MS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ms_cnt  <= '0;
            r_idle_ms <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_ms_cnt  <= w_ms_tick ? '0 : r_ms_cnt + 1'b1;
            r_timeout <= w_expire;
            if ((r_state != S_ENTRY) || bus.key_flag || w_expire)
                r_idle_ms <= '0;
            else if (w_ms_tick && (r_idle_ms != c_IW'(TIMEOUT_MS)))
                r_idle_ms <= r_idle_ms + 1'b1;
        end
    end

    assign bus.timeout = r_timeout;
`else
    logic w_unused_timeout_params;
    assign w_unused_timeout_params = (T1ms != 0) ^ (TIMEOUT_MS != 0);
    assign w_expire    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_entry <= '0;
            r_value <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_entry <= w_entry_nxt;
            r_value <= w_value_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_entry_nxt = r_entry;
        w_value_nxt = r_value;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_COMMIT: begin
                // Any key seen here is dropped; the buffer was already cleared on enter.
                w_state_nxt = S_IDLE;
                w_entry_nxt = '0;
                w_cnt_nxt   = '0;
            end
            default: begin
                if (bus.key_flag) begin
                    if (bus.key_data <= 4'd9) begin
                        if (r_cnt == 4'(DIGITS)) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_entry_nxt = w_shl_wide[c_W-1:0];
                            w_cnt_nxt   = r_cnt + 4'd1;
                            w_state_nxt = S_ENTRY;
                        end
                    end else begin
                        case (bus.key_data)
                            4'hA: begin
                                if (r_cnt == 4'd0) begin
                                    w_err_nxt = 1'b1;
                                end else begin
                                    w_entry_nxt = r_entry >> 4;
                                    w_cnt_nxt   = r_cnt - 4'd1;
                                    if (r_cnt == 4'd1)
                                        w_state_nxt = S_IDLE;
                                end
                            end
                            4'hB: begin
                                if (r_cnt == 4'd0) begin
                                    w_err_nxt = 1'b1;
                                end else begin
                                    w_value_nxt = r_entry;
                                    w_valid_nxt = 1'b1;
                                    w_entry_nxt = '0;
                                    w_cnt_nxt   = '0;
                                    w_state_nxt = S_COMMIT;
                                end
                            end
                            4'hC: begin
                                w_entry_nxt = '0;
                                w_cnt_nxt   = '0;
                                w_state_nxt = S_IDLE;
                            end
                            default: ;
                        endcase
                    end
                end else if (w_expire) begin
                    w_entry_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    assign bus.entry       = r_entry;
    assign bus.entry_cnt   = r_cnt;
    assign bus.value       = r_value;
    assign bus.value_valid = r_valid;
    assign bus.err         = r_err;

endmodule

`default_nettype wire

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Multi-digit numeric entry controller placed directly behind key_pad. It consumes key_pad's 4-bit key code and one-cycle flag, and assembles up to DIGITS decimal digits in BCD. It supports backspace, clear and enter commands. On enter it presents the committed number with a one-cycle valid pulse, for use by downstream display, lock or setpoint logic.

Parameters:
DIGITS, 4, maximum number of BCD digits held (range 1..8)
T1ms, 50_000, clk cycles per 1 ms (50 MHz clock); only used when ENTRY_TIMEOUT_EN is defined
TIMEOUT_MS, 5000, inactivity timeout in ms; only used when ENTRY_TIMEOUT_EN is defined

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
key_data  in  4  key code from key_pad; sampled only when key_flag=1
key_flag  in  1  one-cycle pulse per debounced key press from key_pad
entry  out  4*DIGITS  live entry buffer, BCD; newest digit in bits [3:0]
entry_cnt  out  4  number of digits currently in entry (0..DIGITS)
value  out  4*DIGITS  last committed number, BCD; held until the next commit
value_valid  out  1  one-cycle pulse, asserted in the cycle value updates
err  out  1  one-cycle pulse on an illegal command
timeout  out  1  one-cycle pulse when entry is abandoned by timeout (0 without macro)

Behaviour:
- Key map: 0x0-0x9 = digit; 0xA = backspace; 0xB = enter; 0xC = clear; 0xD-0xF = ignored (no state change, no err).
- Reset: state=IDLE; entry=0, entry_cnt=0, value=0, value_valid=0, err=0, timeout=0; timeout counters=0.
- FSM states: IDLE (entry_cnt=0), ENTRY (entry_cnt>=1), COMMIT (one cycle).
- All decisions act on key_flag in cycle N. Register outputs update at the edge ending cycle N, i.e. they are visible in cycle N+1.
- Digit in IDLE: entry = {0..., d}; entry_cnt=1; go to ENTRY.
- Digit in ENTRY with entry_cnt<DIGITS: entry = {entry[4*DIGITS-5:0], d}; entry_cnt+1.
- Digit in ENTRY with entry_cnt==DIGITS: buffer unchanged; err pulses 1 cycle.
- Backspace in ENTRY: entry shifted right by 4 with zero fill; entry_cnt-1. If the result is 0, go to IDLE.
- Backspace in IDLE: no change; err pulses.
- Clear in any state except COMMIT: entry=0, entry_cnt=0, go to IDLE; no err.
- Enter in ENTRY: value<=entry; value_valid=1 for exactly 1 cycle; go to COMMIT.
- Enter in IDLE: no change; err pulses; value_valid stays 0.
- COMMIT: entry=0, entry_cnt=0; always goes to IDLE after one cycle. A key_flag arriving in COMMIT is dropped silently. Back-to-back keys are ms apart in practice.
- value is never modified except on enter. A leading zero digit counts as a digit: entering 0,0,7 then enter gives value=0x007 and entry_cnt=3 before commit.
- err and value_valid are never asserted together.
- Reset asserted mid-entry returns everything to its reset values immediately (asynchronous); no partial commit.

Optional Feature:
ENTRY_TIMEOUT_EN.
- Defined:
  - A free-running ms prescaler counts 0..T1ms-1 and emits a ms tick.
  - An idle-ms counter runs only in ENTRY and clears on every key_flag and on leaving ENTRY.
  - When the counter reaches TIMEOUT_MS: entry=0, entry_cnt=0, go to IDLE, timeout pulses 1 cycle; value is untouched.
  - A key_flag in the same cycle as expiry takes priority: the key is processed and the counter clears.
- Not defined: no prescaler or counters are synthesized; timeout is tied to 0; ENTRY persists indefinitely.

Test Plan:
- Reset, then key_flag pulses with 1,2,3, then B -> entry=0x0123 and entry_cnt=3 before B. In the cycle after B: value=0x0123, value_valid high for 1 cycle, entry=0, entry_cnt=0.
- Keys 9,8,7,6,5 (DIGITS=4) -> after 4 keys entry=0x9876. 5th key: err pulse, entry stays 0x9876, entry_cnt=4.
- Keys 4,5, A, A, A -> entry=0x0045, then 0x0004, then 0x0000 with state IDLE. Third A: err pulse.
- B pressed in IDLE -> err pulse, value_valid=0, value keeps its previous commit (e.g. 0x0123).
- Keys 2, C, D, E, F -> after C entry=0, entry_cnt=0. D, E and F produce no err and no change.
- With ENTRY_TIMEOUT_EN, T1ms=50, TIMEOUT_MS=3: key 7, then idle 150 clks -> timeout pulse, entry=0, value unchanged. Assert rst_n=0 mid-entry -> all outputs 0 asynchronously.
